// File: rtl/move_entry_if.sv
// Move interface between the player front end and the board model.
// The front end drives C/writeEn; the board returns X/O/gameOver.
interface move_entry_if;
  logic [8:0] C;
  logic       writeEn;
  logic [8:0] X;
  logic [8:0] O;
  logic       gameOver;

  modport master (
    output C, writeEn,
    input  X, O, gameOver
  );

  modport slave (
    input  C, writeEn,
    output X, O, gameOver
  );
endinterface

// File: rtl/move_entry.sv
// Tic-tac-toe player input: debounced buttons, 3x3 cursor,
// and a shaped writeEn pulse for the board model.
module move_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 4,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_sel,
  move_entry_if.master mv,
  output logic [3:0]   cursor,
  output logic         blink,
  output logic         rejected
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_CYCLES - 1);

  localparam int UP = 0, DN = 1, LT = 2, RT = 3, SL = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMMIT  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  logic [4:0]    btn;
  logic [4:0]    s1_q, s2_q;
  logic [4:0]    stab_q, stab_d;
  logic [4:0]    rise_q;
  logic [DW-1:0] db_q [5];
  logic [DW-1:0] db_d [5];

  state_e        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    cur_q, cur_d;
  logic          rej_q, rej_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;

  logic [1:0]    row, col;
  logic [3:0]    rbase;
  logic          legal;

  assign btn = {btn_sel, btn_right, btn_left, btn_down, btn_up};

  function automatic logic [3:0] idx(input logic [1:0] r,
                                     input logic [1:0] c);
    return 4'(r) * 4'd3 + 4'(c);
  endfunction

  // Debounce: accept only after DEBOUNCE_CYCLES clocks of disagreement
  always_comb begin
    stab_d = stab_q;
    for (int i = 0; i < 5; i++) begin
      db_d[i] = '0;
      if (s2_q[i] != stab_q[i]) begin
        if (db_q[i] == DMAX) stab_d[i] = s2_q[i];
        else db_d[i] = db_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      stab_q <= '0;
      rise_q <= '0;
      for (int i = 0; i < 5; i++) db_q[i] <= '0;
    end else begin
      s1_q   <= btn;
      s2_q   <= s1_q;
      stab_q <= stab_d;
      rise_q <= stab_d & ~stab_q;
      for (int i = 0; i < 5; i++) db_q[i] <= db_d[i];
    end
  end

  always_comb begin
    row   = (cur_q >= 4'd6) ? 2'd2 :
            (cur_q >= 4'd3) ? 2'd1 : 2'd0;
    rbase = 4'(row) * 4'd3;
    col   = 2'(cur_q - rbase);
  end

  assign legal = !mv.gameOver &&
                 (((mv.X | mv.O) & mv.C) == 9'd0);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cur_d   = cur_q;
    rej_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Priority sel > up > down > left > right
        if (rise_q[SL]) begin
          if (legal) begin
            state_d = COMMIT;
            hold_d  = '0;
          end else begin
            rej_d = 1'b1;
          end
        end else if (rise_q[UP]) begin
          cur_d = idx((row == 2'd0) ? 2'd2 : row - 2'd1, col);
        end else if (rise_q[DN]) begin
          cur_d = idx((row == 2'd2) ? 2'd0 : row + 2'd1, col);
        end else if (rise_q[LT]) begin
          cur_d = idx(row, (col == 2'd0) ? 2'd2 : col - 2'd1);
        end else if (rise_q[RT]) begin
          cur_d = idx(row, (col == 2'd2) ? 2'd0 : col + 2'd1);
        end
      end
      COMMIT: begin
        if (hold_q == HMAX) begin
          state_d = RELEASE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!stab_q[SL]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Restart blink on cursor moves so the new cell shows at once
  always_comb begin
    bcnt_d  = bcnt_q + 1'b1;
    blink_d = blink_q;
    if (cur_d != cur_q) begin
      bcnt_d  = '0;
      blink_d = 1'b0;
    end else if (bcnt_q == BMAX) begin
      bcnt_d  = '0;
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cur_q   <= 4'd4;
      rej_q   <= 1'b0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cur_q   <= cur_d;
      rej_q   <= rej_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  assign mv.C       = 9'd1 << cur_q;
  assign mv.writeEn = (state_q == COMMIT);
  assign cursor     = cur_q;
  assign blink      = blink_q;
  assign rejected   = rej_q;

endmodule

// File: tb/tb_move_entry.sv
// Directed bench for move_entry: debounce, navigation, commit
// handshake, illegal selects, priority and mid-pulse reset.
module tb_move_entry;

  localparam int D = 4;
  localparam int H = 3;
  localparam int B = 8;
  localparam int UP = 0, DN = 1, LT = 2, RT = 3, SL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn;
  logic [3:0] cursor;
  logic       blink;
  logic       rejected;

  move_entry_if mv();

  move_entry #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .BLINK_CYCLES(B)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn[UP]),
    .btn_down(btn[DN]),
    .btn_left(btn[LT]),
    .btn_right(btn[RT]),
    .btn_sel(btn[SL]),
    .mv(mv.master),
    .cursor(cursor),
    .blink(blink),
    .rejected(rejected)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int we_hi, we_rise, rej_hi, c_bad, blink_tog, blink_bad;
  logic       prev_we, prev_blink;
  logic [3:0] prev_cur;
  logic [8:0] prev_c;
  logic       found;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    we_hi = 0; we_rise = 0; rej_hi = 0;
    c_bad = 0; blink_tog = 0; blink_bad = 0;
    prev_we = mv.writeEn; prev_c = mv.C;
    prev_blink = blink; prev_cur = cursor;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (mv.writeEn === 1'b1) begin
        we_hi++;
        if (prev_we !== 1'b1) we_rise++;
        else if (mv.C !== prev_c) c_bad++;
      end
      if (rejected === 1'b1) rej_hi++;
      if (blink !== prev_blink) blink_tog++;
      if (cursor !== prev_cur && blink !== 1'b0) blink_bad++;
      prev_we = mv.writeEn; prev_c = mv.C;
      prev_blink = blink; prev_cur = cursor;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    btn = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clr();
  endtask

  task automatic press(input int b, input int hold);
    btn[b] = 1'b1;
    step(hold);
    btn[b] = 1'b0;
    step(12);
  endtask

  initial begin
    reset = 1'b1;
    btn = '0;
    mv.X = '0;
    mv.O = '0;
    mv.gameOver = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cursor", 32'(cursor), 32'd4);
    check("rst_C", 32'(mv.C), 32'h010);
    check("rst_we", 32'(mv.writeEn), 32'd0);
    check("rst_rej", 32'(rejected), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    reset = 1'b0;
    clr();

    step(64);
    check("blink_toggles", 32'(blink_tog), 32'd8);

    press(RT, 3);
    check("glitch_cursor", 32'(cursor), 32'd4);
    press(RT, 10);
    check("deb_cursor", 32'(cursor), 32'd5);
    check("deb_C", 32'(mv.C), 32'h020);

    do_reset();
    press(RT, 10);
    check("wrap_r1", 32'(cursor), 32'd5);
    press(RT, 10);
    check("wrap_r2", 32'(cursor), 32'd3);
    press(UP, 10);
    check("wrap_u1", 32'(cursor), 32'd0);
    press(UP, 10);
    check("wrap_u2", 32'(cursor), 32'd6);
    press(DN, 10);
    check("wrap_d1", 32'(cursor), 32'd0);
    press(LT, 10);
    check("wrap_l1", 32'(cursor), 32'd2);
    check("wrap_C", 32'(mv.C), 32'h004);
    check("blink_on_move", 32'(blink_bad), 32'd0);

    do_reset();
    btn[SL] = 1'b1;
    step(16);
    check("commit_hi", 32'(we_hi), 32'd3);
    check("commit_rise", 32'(we_rise), 32'd1);
    check("commit_C", 32'(c_bad), 32'd0);
    check("commit_cursor", 32'(cursor), 32'd4);
    btn[RT] = 1'b1;
    step(10);
    btn[RT] = 1'b0;
    step(12);
    check("held_sel_hi", 32'(we_hi), 32'd3);
    check("nav_dropped", 32'(cursor), 32'd4);
    btn[SL] = 1'b0;
    step(12);
    check("release_rise", 32'(we_rise), 32'd1);
    press(SL, 10);
    check("rearm_rise", 32'(we_rise), 32'd2);
    check("rearm_hi", 32'(we_hi), 32'd6);
    check("rearm_C", 32'(c_bad), 32'd0);

    do_reset();
    mv.X = 9'h010;
    press(SL, 10);
    check("occ_we", 32'(we_hi), 32'd0);
    check("occ_rej", 32'(rej_hi), 32'd1);
    mv.X = '0;
    mv.gameOver = 1'b1;
    clr();
    press(SL, 10);
    check("over_we", 32'(we_hi), 32'd0);
    check("over_rej", 32'(rej_hi), 32'd1);
    mv.gameOver = 1'b0;

    do_reset();
    btn[SL] = 1'b1;
    btn[RT] = 1'b1;
    step(16);
    btn = '0;
    step(12);
    check("prio_hi", 32'(we_hi), 32'd3);
    check("prio_cursor", 32'(cursor), 32'd4);
    check("prio_rej", 32'(rej_hi), 32'd0);

    do_reset();
    press(RT, 10);
    check("pre_mid_cursor", 32'(cursor), 32'd5);
    press(LT, 10);
    btn[SL] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #1;
      if (mv.writeEn === 1'b1) found = 1'b1;
    end
    check("mid_found", 32'(found), 32'd1);
    @(posedge clk); #1;
    check("mid_we2", 32'(mv.writeEn), 32'd1);
    reset = 1'b1;
    btn = '0;
    #1;
    check("mid_we_drop", 32'(mv.writeEn), 32'd0);
    check("mid_cursor", 32'(cursor), 32'd4);
    @(posedge clk); #1;
    reset = 1'b0;
    clr();
    press(RT, 10);
    check("mid_idle_nav", 32'(cursor), 32'd5);
    check("mid_no_we", 32'(we_hi), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/move_entry.md
Name: move_entry

Overview:
- Player-input front end for the tic-tac-toe board model; it is the producer side of the board model's move interface.
- Debounces five push-buttons: up, down, left, right, select.
- Maintains a 3x3 cursor and drives the one-hot cell select C plus a writeEn pulse shaped for the board model's arm/commit/re-arm handshake.
- Reads the board state X/O and gameOver so that illegal moves are never issued.

Parameters:
- DEBOUNCE_CYCLES, 500000, clocks a synchronized button level must stay constant before it is accepted (10 ms at 50 MHz).
- HOLD_CYCLES, 4, clocks writeEn is held high per committed move (min 1).
- BLINK_CYCLES, 12500000, clocks per half-period of the cursor blink output.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high; clears all state.
- btn_up, btn_down, btn_left, btn_right, btn_sel  input  1 each  raw asynchronous push-buttons, active-high.
- X  input  9  cells occupied by X (bit i = cell i, row-major, cell 0 top-left).
- O  input  9  cells occupied by O.
- gameOver  input  1  match finished; blocks commits.
- C  output  9  one-hot select of the cursor cell.
- writeEn  output  1  move-commit strobe to the board model.
- cursor  output  4  cursor index 0..8.
- blink  output  1  cursor blink phase for the display.
- rejected  output  1  one-cycle pulse when a select is refused.

Behaviour:
- Reset values (asynchronous, active-high):
  - cursor=4, C=9'b000010000, writeEn=0, blink=0, rejected=0.
  - State=IDLE; all debounce, hold and blink counters=0; debounced levels=0.
- Input path:
  - Each button passes through a 2-flop synchronizer into its own debouncer.
  - If the synchronized level differs from the stable level, the counter increments; on reaching DEBOUNCE_CYCLES-1 the stable level takes the new value and the counter clears.
  - If the synchronized level equals the stable level, the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are never accepted.
  - Only the 0->1 edge of a stable level is an event; one event per press, no auto-repeat.
- Navigation (IDLE only): with row = cursor/3, col = cursor%3:
  - up: row-1, wrapping 0->2.
  - down: row+1, wrapping 2->0.
  - left: col-1, wrapping 0->2.
  - right: col+1, wrapping 2->0.
  - Wrapping stays within the same column or row.
  - cursor and C update on the clock after the event.
  - C is always one-hot of cursor and never all-zero.
- Simultaneous events in the same cycle: only the highest-priority event acts, priority sel > up > down > left > right; the other events are dropped.
- State machine:
  - IDLE: on a sel event, evaluate legality with the current X, O and gameOver.
    - If legal (gameOver=0 and ((X|O)&C)==0): go to COMMIT; writeEn=1 on the next clock.
    - If illegal: rejected=1 for exactly one cycle, stay in IDLE.
  - COMMIT: writeEn=1 for exactly HOLD_CYCLES clocks; cursor and C frozen; navigation events dropped. Then writeEn=0 and go to RELEASE.
  - RELEASE: writeEn=0; navigation events dropped; go to IDLE on the first clock where debounced sel=0, i.e. on that clock if sel is already released.
- Handshake guarantees:
  - writeEn is never high on two consecutive moves without at least one low clock between them.
  - C is stable throughout every writeEn-high window.
- Blink:
  - The counter runs in all states; blink toggles every BLINK_CYCLES clocks.
  - The counter and blink are forced to 0 for one cycle on any cursor change, so the new cell is shown immediately.
- Changes to X/O/gameOver during COMMIT or RELEASE do not abort the pulse.
- Reset asserted mid-COMMIT: writeEn drops asynchronously, state returns to IDLE, and the cursor returns to 4.

Test Plan:
- Reset check (DEBOUNCE_CYCLES=4, HOLD_CYCLES=3, BLINK_CYCLES=8 for all tests): assert reset -> cursor=4, C=9'h010, writeEn=0, rejected=0.
- Glitch and debounce:
  - Pulse btn_right high for 3 clocks -> cursor remains 4.
  - Hold btn_right high for 10 clocks -> cursor=5, C=9'h020, exactly one step.
- Wrap-around: from reset, press right twice -> cursor 5 then 3. Press up twice -> cursor 0 then 6. Press down once -> cursor 0.
- Legal commit with X=O=0 at cursor 4:
  - Press sel -> writeEn high for exactly 3 clocks with C=9'h010.
  - Next sel press ignored until btn_sel is released and debounced low.
  - Navigation presses during the pulse do not move the cursor.
- Illegal selects:
  - X=9'h010, cursor 4, press sel -> writeEn stays 0, rejected pulses 1 cycle.
  - X=O=0, gameOver=1, press sel -> same result.
- Priority and reset:
  - btn_sel and btn_right debounced-high on the same clock at cursor 4 -> commit of cell 4, cursor unchanged.
  - Assert reset on the 2nd writeEn-high clock -> writeEn=0 immediately, state IDLE, cursor=4.
